// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins; auxiliary
// writes are buffered in a small FIFO. When the FIFO is empty and the port is
// free, an auxiliary write cuts through directly. Also reports which registers
// have buffered writes pending, and requests a pipeline stall when the FIFO
// head waits too long.
module rf_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_wr,
  input  logic [31:0]              wb_wd,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [4:0]               aux_wr,
  input  logic [31:0]              aux_wd,
  output logic                     rf_write,
  output logic [4:0]               rf_wr,
  output logic [31:0]              rf_wd,
  input  logic [4:0]               q1,
  input  logic [4:0]               q2,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    r_wr_mem [DEPTH];
  logic [31:0]   r_wd_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [3:0]    r_starve;
  logic          r_stall;

  logic          w_empty;
  logic          w_accept;
  logic          w_wb_write;
  logic          w_pop;
  logic          w_cut;
  logic          w_push;
  logic [3:0]    w_starve_nxt;

  assign w_empty    = (r_count == '0);
  assign aux_ready  = ~reset & (r_count < CW'(DEPTH));
  assign w_accept   = aux_valid & aux_ready;
  assign w_wb_write = wb_valid & (wb_wr != 5'd0);
  assign w_pop      = ~reset & ~w_wb_write & ~w_empty;
  assign w_cut      = ~reset & ~w_wb_write & w_empty & w_accept & (aux_wr != 5'd0);
  // Writes to r0 are acknowledged but dropped.
  assign w_push     = w_accept & (aux_wr != 5'd0) & ~w_cut;

  assign fifo_count = r_count;
  assign stall_req  = r_stall;

  // Write-port mux: WB, then FIFO head, then cut-through, else idle.
  always_comb begin
    rf_write = 1'b0;
    rf_wr    = 5'd0;
    rf_wd    = 32'd0;
    if (!reset) begin
      if (w_wb_write) begin
        rf_write = 1'b1;
        rf_wr    = wb_wr;
        rf_wd    = wb_wd;
      end else if (!w_empty) begin
        rf_write = 1'b1;
        rf_wr    = r_wr_mem[r_head];
        rf_wd    = r_wd_mem[r_head];
      end else if (w_cut) begin
        rf_write = 1'b1;
        rf_wr    = aux_wr;
        rf_wd    = aux_wd;
      end
    end
  end

  // Pending-write lookup over buffered entries only.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_wr_mem[i] == q1)) busy1 = 1'b1;
      if (r_vld[i] && (r_wr_mem[i] == q2)) busy2 = 1'b1;
    end
    if (q1 == 5'd0) busy1 = 1'b0;
    if (q2 == 5'd0) busy2 = 1'b0;
  end

  // Saturating head-wait counter for the next cycle.
  always_comb begin
    w_starve_nxt = 4'd0;
    if (!w_empty && !w_pop) begin
      w_starve_nxt = (r_starve == 4'd15) ? 4'd15 : r_starve + 4'd1;
    end
  end

  // FIFO storage; contents need no reset since r_vld/r_count gate their use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wr_mem[r_tail] <= aux_wr;
      r_wd_mem[r_tail] <= aux_wd;
    end
  end

  // FIFO pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_tail        <= r_tail + AW'(1);
        r_vld[r_tail] <= 1'b1;
      end
      if (w_pop) begin
        r_head        <= r_head + AW'(1);
        r_vld[r_head] <= 1'b0;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Starvation counter and registered stall request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= 4'd0;
      r_stall  <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      if (w_pop) begin
        r_stall <= 1'b0;
      end else if (w_starve_nxt >= 4'(STARVE_LIMIT)) begin
        r_stall <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected register-file writes are queued
// as stimulus is issued and checked in order by a monitor; status outputs are
// checked directly against hand-derived values.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_wr;
  logic [31:0] wb_wd;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_wr;
  logic [31:0] aux_wd;
  logic        rf_write;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic [4:0]  q1;
  logic [4:0]  q2;
  logic        busy1;
  logic        busy2;
  logic        stall_req;
  logic [1:0]  fifo_count;

  int total = 0;
  int bad   = 0;
  bit done  = 0;
  logic [36:0] exp_q [$];

  rf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_wr(wb_wr), .wb_wd(wb_wd),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_wr(aux_wr), .aux_wd(aux_wd),
    .rf_write(rf_write), .rf_wr(rf_wr), .rf_wd(rf_wd),
    .q1(q1), .q2(q2), .busy1(busy1), .busy2(busy2),
    .stall_req(stall_req), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  // Drive one cycle's inputs just after the edge; checks follow at +2.
  task automatic cyc(input logic rst, input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                     input logic av, input logic [4:0] ar, input logic [31:0] ad);
    @(posedge clk);
    #1;
    reset = rst; wb_valid = wv; wb_wr = wr; wb_wd = wd;
    aux_valid = av; aux_wr = ar; aux_wd = ad;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  initial begin
    logic [36:0] e;
    reset = 1'b1; wb_valid = 1'b0; wb_wr = 5'd0; wb_wd = 32'd0;
    aux_valid = 1'b0; aux_wr = 5'd0; aux_wd = 32'd0; q1 = 5'd0; q2 = 5'd0;
    fork
      begin
        while (!done) begin
          @(negedge clk);
          if (rf_write === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL rf_unexpected: got wr=%0d wd=%h, expected no write", rf_wr, rf_wd);
            end else begin
              e = exp_q.pop_front();
              if ({rf_wr, rf_wd} !== e) begin
                bad++;
                $display("FAIL rf_write: got wr=%0d wd=%h, expected wr=%0d wd=%h",
                         rf_wr, rf_wd, e[36:32], e[31:0]);
              end
            end
          end
        end
      end
      begin
        // Reset
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66);
        chk("rst_aux_ready", 32'(aux_ready), 32'd0);
        chk("rst_rf_write", 32'(rf_write), 32'd0);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);

        // Cut-through
        q1 = 5'd5;
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hAAAA0001);
        expect_wr(5'd5, 32'hAAAA0001);
        chk("ct_ready", 32'(aux_ready), 32'd1);
        chk("ct_count", 32'(fifo_count), 32'd0);
        chk("ct_busy", 32'(busy1), 32'd0);
        idle();
        chk("ct_count_after", 32'(fifo_count), 32'd0);
        chk("ct_busy_after", 32'(busy1), 32'd0);

        // WB priority, FIFO fill, drain order, busy
        q1 = 5'd7; q2 = 5'd8;
        cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h77);
        expect_wr(5'd3, 32'h11);
        chk("pri_count0", 32'(fifo_count), 32'd0);
        cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd8, 32'h88);
        expect_wr(5'd3, 32'h11);
        chk("pri_count1", 32'(fifo_count), 32'd1);
        chk("pri_busy1_r7", 32'(busy1), 32'd1);
        chk("pri_ready1", 32'(aux_ready), 32'd1);
        cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd10, 32'hAA);
        expect_wr(5'd3, 32'h11);
        chk("full_ready", 32'(aux_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'd2);
        chk("full_busy2_r8", 32'(busy2), 32'd1);
        idle();
        expect_wr(5'd7, 32'h77);
        chk("drain_busy1_incl", 32'(busy1), 32'd1);
        chk("drain_count2", 32'(fifo_count), 32'd2);
        idle();
        expect_wr(5'd8, 32'h88);
        chk("drain_busy1_clear", 32'(busy1), 32'd0);
        chk("drain_busy2", 32'(busy2), 32'd1);
        chk("drain_count1", 32'(fifo_count), 32'd1);
        idle();
        chk("drain_count0", 32'(fifo_count), 32'd0);
        chk("drain_busy2_clear", 32'(busy2), 32'd0);

        // Starvation
        q1 = 5'd12;
        cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd12, 32'hC12);
        expect_wr(5'd3, 32'h11);
        chk("stv_stall_c0", 32'(stall_req), 32'd0);
        for (int i = 1; i <= 4; i++) begin
          cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
          expect_wr(5'd3, 32'h11);
          chk($sformatf("stv_stall_c%0d", i), 32'(stall_req), 32'd0);
        end
        cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd3, 32'h11);
        chk("stv_stall_rise", 32'(stall_req), 32'd1);
        chk("stv_count", 32'(fifo_count), 32'd1);
        idle();
        expect_wr(5'd12, 32'hC12);
        chk("stv_stall_hold", 32'(stall_req), 32'd1);
        chk("stv_busy_head", 32'(busy1), 32'd1);
        idle();
        chk("stv_stall_fall", 32'(stall_req), 32'd0);
        chk("stv_count0", 32'(fifo_count), 32'd0);

        // WB to r0 leaves port free for FIFO head
        q1 = 5'd9;
        cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd9, 32'h99);
        expect_wr(5'd3, 32'h11);
        cyc(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd9, 32'h99);
        chk("r0wb_busy", 32'(busy1), 32'd1);
        idle();
        chk("r0wb_count", 32'(fifo_count), 32'd0);

        // Aux write to r0 is discarded
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD);
        chk("r0aux_ready", 32'(aux_ready), 32'd1);
        chk("r0aux_rf_write", 32'(rf_write), 32'd0);
        idle();
        chk("r0aux_count", 32'(fifo_count), 32'd0);

        // Reset flushes buffered entries
        q1 = 5'd20; q2 = 5'd21;
        cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd20, 32'h20);
        expect_wr(5'd3, 32'h11);
        cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd21, 32'h21);
        expect_wr(5'd3, 32'h11);
        chk("fl_count1", 32'(fifo_count), 32'd1);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'h22);
        chk("fl_count2", 32'(fifo_count), 32'd2);
        chk("fl_rst_rf_write", 32'(rf_write), 32'd0);
        chk("fl_rst_ready", 32'(aux_ready), 32'd0);
        idle();
        chk("fl_count0", 32'(fifo_count), 32'd0);
        chk("fl_stall", 32'(stall_req), 32'd0);
        chk("fl_busy1", 32'(busy1), 32'd0);
        chk("fl_busy2", 32'(busy2), 32'd0);
        chk("fl_ready", 32'(aux_ready), 32'd1);
        repeat (3) idle();
        done = 1'b1;
      end
    join
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port between two sources. The first is the main pipeline writeback (WB stage). The second is a long-latency auxiliary unit, such as a multiply/divide unit or a load-miss return path. WB always has priority; auxiliary writes use a valid/ready handshake and wait in a small FIFO. The block also reports pending-write scoreboard bits to the hazard unit, and raises a stall request if an auxiliary write waits too long.

Parameters:
DEPTH, 2, auxiliary FIFO entries (power of two, 2..8).
STARVE_LIMIT, 4, consecutive cycles the FIFO head may wait before stall_req asserts (1..15).

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
wb_valid  in  1  pipeline WB stage writes this cycle
wb_wr  in  5  WB destination register
wb_wd  in  32  WB write data
aux_valid  in  1  auxiliary unit offers a write
aux_ready  out  1  arbiter can accept the auxiliary write
aux_wr  in  5  auxiliary destination register
aux_wd  in  32  auxiliary write data
rf_write  out  1  register file write enable
rf_wr  out  5  register file write address
rf_wd  out  32  register file write data
q1, q2  in  5  hazard-unit query registers (decode rs/rt)
busy1, busy2  out  1  queried register has a buffered pending auxiliary write
stall_req  out  1  registered request that the pipeline freeze WB
fifo_count  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: reset is reset, synchronous, active-high; the clock is clk.
- Reset: FIFO pointers, fifo_count, wait counter and stall_req all clear to 0.
- While reset=1, rf_write=0 and aux_ready=0; no handshake completes.
- aux_ready = (fifo_count < DEPTH). This is combinational from registered state; there is no pop-through when full.
- Accept condition: aux_valid & aux_ready.
- A "WB write" means wb_valid=1 and wb_wr≠0. wb_valid with wb_wr=0 is no write and leaves the port free.
- Port priority each cycle (combinational outputs):
  1. WB write: rf_write=1, rf_wr=wb_wr, rf_wd=wb_wd.
  2. Else, FIFO non-empty: drive the head entry and pop it at the clock edge.
  3. Else, accepted aux write with aux_wr≠0 and FIFO empty: cut-through. Drive aux_wr/aux_wd directly; nothing is enqueued.
  4. Else rf_write=0; rf_wr and rf_wd drive 0.
- Any accepted aux write not written by cut-through is enqueued at the tail.
  - Push and pop may occur in the same cycle (count unchanged).
  - FIFO preserves acceptance order. Pointers wrap modulo DEPTH.
- Accepted aux write with aux_wr=0: handshake completes, data is discarded, nothing is enqueued or written.
- Starvation counter (4 bits):
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on a pop or when the FIFO is empty.
  - Saturates at 15.
- stall_req: registered; set to 1 on the edge where the counter's next value is ≥ STARVE_LIMIT; cleared on the edge where a pop occurs.
- Pipeline contract while stall_req=1: hold wb_valid=0.
  - If wb_valid=1 anyway, WB still wins and stall_req stays high.
  - The first cycle with no WB write pops the head. stall_req is 0 in the following cycle, unless the counter re-reaches the limit.
- busy1 = q1≠0 and any valid FIFO entry has wr==q1; busy2 likewise. Evaluated on registered FIFO contents, so the head being written this cycle still reads busy.
  - Cut-through writes never set busy.
- Write ordering between WB and buffered aux writes to the same register is not checked here. The hazard unit uses busy1/busy2 to prevent it.
- Reset asserted mid-operation discards all buffered entries without writing them.

Test Plan:
- After reset, aux_valid=1, aux_wr=5, aux_wd=0xAAAA0001, wb_valid=0 -> same cycle rf_write=1, rf_wr=5, rf_wd=0xAAAA0001; fifo_count stays 0; busy never asserts for r5.
- wb_valid=1, wb_wr=3, wb_wd=0x11 for 3 cycles; aux offers r7/0x77 then r8/0x88 -> rf writes r3 for 3 cycles; aux_ready=0 once fifo_count=2; next free cycle writes r7, then r8; busy1 with q1=7 is high until r7's write cycle inclusive.
- Continuous WB writes with 1 aux entry queued, STARVE_LIMIT=4 -> stall_req rises after 4 waiting cycles; bench drops wb_valid; head written the next cycle; stall_req low one cycle later.
- wb_valid=1, wb_wr=0 while FIFO holds r9/0x99 -> rf_write=1, rf_wr=9 (r0 write ignored).
- aux write to r0 with FIFO empty -> handshake completes, rf_write=0, fifo_count=0.
- Fill FIFO (2 entries), pulse reset for 1 cycle -> fifo_count=0, stall_req=0, busy1/busy2=0, no rf write of flushed entries.
